// File: rtl/branch_update_unit.sv
// rtl/branch_update_unit.sv - 2-bit predictor table write side: counter update, forwarding, update FIFO, mispredict redirect.
// Optional BRANCH_STATS_EN adds branch/mispredict event counters.
module branch_update_unit #(
  parameter int IDX_W = 2,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [IDX_W-1:0] res_idx,
  input  logic [1:0]       res_state,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  input  logic [PC_W-1:0]  res_pc_plus4,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [IDX_W-1:0] wr_idx,
  output logic [1:0]       wr_entry,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispredicts
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0] mem_idx [DEPTH];
  logic [1:0]       mem_st  [DEPTH];
  logic [PTR_W-1:0] rptr, wptr, rptr_next;
  logic [PTR_W:0]   count, count_after_pop, count_next;
  logic             full, push, pop;
  logic [1:0]       old_state, new_state;
  logic [IDX_W-1:0] head_idx_next;
  logic [1:0]       head_st_next;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign wr_valid  = (count != '0);
  assign pop       = wr_valid && wr_ready;
  assign res_ready = !full || pop;
  assign push      = res_valid && res_ready;

  // Newest queued update to the same index wins, so back-to-back updates accumulate.
  always_comb begin
    old_state = res_state;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count) && (mem_idx[rptr + PTR_W'(i)] == res_idx)) begin
        old_state = mem_st[rptr + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    new_state = old_state;
    if (res_taken) begin
      if (old_state != 2'b11) new_state = old_state + 2'b01;
    end else begin
      if (old_state != 2'b00) new_state = old_state - 2'b01;
    end
  end

  always_comb begin
    count_after_pop = count - (PTR_W+1)'(pop);
    count_next      = count_after_pop + (PTR_W+1)'(push);
    rptr_next       = rptr + PTR_W'(pop);
    head_idx_next   = mem_idx[rptr_next];
    head_st_next    = mem_st[rptr_next];
    if (count_after_pop == '0) begin
      head_idx_next = res_idx;
      head_st_next  = new_state;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx[wptr] <= res_idx;
      mem_st[wptr]  <= new_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      rptr     <= '0;
      wptr     <= '0;
      wr_idx   <= '0;
      wr_entry <= 2'b00;
    end else begin
      count <= count_next;
      rptr  <= rptr_next;
      if (push) wptr <= wptr + PTR_W'(1);
      // Head registers hold their last value once the queue drains.
      if (count_next != '0) begin
        wr_idx   <= head_idx_next;
        wr_entry <= head_st_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= push && (res_state[1] != res_taken);
      if (push && (res_state[1] != res_taken)) begin
        redirect_pc <= res_taken ? res_target : res_pc_plus4;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (push)       stat_branches    <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_update_unit.md
Name: branch_update_unit

Overview:
- Write side of the 2-bit branch prediction table: takes resolved branches from EX and produces the table write (index, new counter state).
- Computes the saturating-counter update and detects mispredictions, driving the one-cycle redirect/flush to fetch.
- Queues updates in a small FIFO so that a busy table write port never stalls EX.

Parameters:
- IDX_W, 2, table index width (table has 2**IDX_W entries)
- PC_W, 32, program counter width
- DEPTH, 2, update FIFO depth (power of 2, >=2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- res_valid  input  1  resolved branch present in EX
- res_ready  output  1  unit can accept a resolved branch
- res_idx  input  IDX_W  table index the branch was predicted with
- res_state  input  2  counter state read at fetch, carried down the pipe
- res_taken  input  1  actual outcome
- res_target  input  PC_W  computed branch target
- res_pc_plus4  input  PC_W  fall-through address
- wr_valid  output  1  table write request
- wr_ready  input  1  table accepts the write this cycle
- wr_idx  output  IDX_W  table write index
- wr_entry  output  2  new counter state
- mispredict  output  1  one-cycle flush/redirect pulse
- redirect_pc  output  PC_W  correct next PC, valid while mispredict=1

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; wr_valid=0, wr_idx=0, wr_entry=00.
  - mispredict=0, redirect_pc=0.
  - res_ready=1 once reset deasserts.
- Counter encoding:
  - 00 = strong not-taken, 01 = weak NT, 10 = weak T, 11 = strong T.
  - Prediction bit = state[1].
- Update rule:
  - taken: state+1, saturating at 11.
  - not taken: state-1, saturating at 00.
- Effective old state (forwarding):
  - If any FIFO entry, or an entry being pushed this same cycle, targets res_idx, the newest such entry's new state replaces res_state.
  - Otherwise res_state is used.
  - This ensures back-to-back updates to one index accumulate instead of overwriting each other.
- Accept: a transfer happens when res_valid && res_ready.
  - The computed {idx, new state} is pushed to the FIFO on that clk edge.
  - res_ready = !full, or full with a pop in the same cycle (combinational from wr_ready).
- Mispredict:
  - Computed from the pipeline-carried res_state[1] != res_taken, not the forwarded state.
  - Registered: mispredict=1 on the cycle after the accept, for exactly one cycle.
  - redirect_pc = res_taken ? res_target : res_pc_plus4, latched together with mispredict.
  - The pulse is independent of FIFO occupancy and wr_ready.
- Write port:
  - wr_valid = !empty; wr_idx/wr_entry come from the FIFO head (registered outputs).
  - Pop on wr_valid && wr_ready.
  - Minimum latency from accept to wr_valid: 1 cycle.
  - wr_idx/wr_entry stay stable while wr_valid=1 && wr_ready=0.
- Simultaneous push and pop:
  - Allowed in every state, including full.
  - Occupancy is unchanged; pointers wrap modulo DEPTH.
- Empty FIFO: wr_valid=0, wr_idx/wr_entry hold their last values.
- Full FIFO with no pop: res_ready=0; the upstream branch stalls and no mispredict is generated for it.
- Reset mid-operation:
  - Pending updates are discarded and a mispredict pulse in flight is cancelled.
  - The table contents are not this unit's responsibility.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0], reset to 0.
  - stat_branches increments on each accepted branch; stat_mispredicts increments on each mispredict pulse.
  - Both wrap at 2**32 and are never saturated.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then accept idx=1, state=01, taken=1, target=0x40, wr_ready=1:
  - next cycle wr_valid=1, wr_idx=1, wr_entry=10, mispredict=1, redirect_pc=0x40
  - one cycle later mispredict=0, wr_valid=0
- Saturation:
  - state=11, taken=1 -> wr_entry=11, mispredict=0
  - state=00, taken=0 -> wr_entry=00, mispredict=0
  - state=10, taken=0, pc_plus4=0x14 -> wr_entry=01, mispredict=1, redirect_pc=0x14
- Forwarding, wr_ready=0: two consecutive accepts to idx=2, both state=00, taken=1 -> FIFO holds 01 then 10; raising wr_ready writes 01 then 10.
- Back-pressure with DEPTH=2, wr_ready=0:
  - third accept attempt sees res_ready=0 and no mispredict pulse
  - with FIFO full, wr_ready=1 and res_valid=1 -> push and pop in the same cycle, occupancy stays 2
- Assert reset low asynchronously while the FIFO holds 2 entries and mispredict=1 -> wr_valid=0 and mispredict=0 immediately, without waiting for clk.
- With BRANCH_STATS_EN, 5 branches with 2 mispredicts -> stat_branches=5, stat_mispredicts=2.
